// File: rtl/jac_pkg.sv
// rtl/jac_pkg.sv - Jac1-8 opcodes, status bit indices and decode bundle type
package jac_pkg;

    localparam int DataWidth  = 8;
    localparam int SelWidth   = 2;
    localparam int ParamBits  = 8;
    localparam int OpcodeBits = 5;
    localparam int StatusBits = 6;

    localparam logic [OpcodeBits-1:0] Op_NOP   = 5'b00000;
    localparam logic [OpcodeBits-1:0] Op_ADD   = 5'b00001;
    localparam logic [OpcodeBits-1:0] Op_SUB   = 5'b00010;
    localparam logic [OpcodeBits-1:0] Op_AND   = 5'b00011;
    localparam logic [OpcodeBits-1:0] Op_OR    = 5'b00100;
    localparam logic [OpcodeBits-1:0] Op_XOR   = 5'b00101;
    localparam logic [OpcodeBits-1:0] Op_NOT   = 5'b00110;
    localparam logic [OpcodeBits-1:0] Op_SHL   = 5'b00111;
    localparam logic [OpcodeBits-1:0] Op_SHR   = 5'b01000;
    localparam logic [OpcodeBits-1:0] Op_ADDC  = 5'b01001;
    localparam logic [OpcodeBits-1:0] Op_SUBU  = 5'b01010;
    localparam logic [OpcodeBits-1:0] Op_VAL   = 5'b01011;
    localparam logic [OpcodeBits-1:0] Op_CMP   = 5'b01100;
    localparam logic [OpcodeBits-1:0] Op_CLRST = 5'b01101;
    localparam logic [OpcodeBits-1:0] Op_GOTO  = 5'b10000;
    localparam logic [OpcodeBits-1:0] Op_IFZ   = 5'b10001;
    localparam logic [OpcodeBits-1:0] Op_IFNZ  = 5'b10010;
    localparam logic [OpcodeBits-1:0] Op_IFEQ  = 5'b10011;
    localparam logic [OpcodeBits-1:0] Op_IFST  = 5'b10100;
    localparam logic [OpcodeBits-1:0] Op_IFGT  = 5'b10101;

    localparam int CarryBit       = 0;
    localparam int UnderflowBit   = 1;
    localparam int ZeroBit        = 2;
    localparam int EqualBit       = 3;
    localparam int GreaterThanBit = 4;
    localparam int SmallerThanBit = 5;

    localparam logic SEL_ALU     = 1'b1;
    localparam logic SEL_DECODER = 1'b0;

    typedef struct packed {
        logic [OpcodeBits-1:0] opcode;
        logic [ParamBits-1:0]  param;
        logic [DataWidth-1:0]  literal_adr;
        logic [SelWidth-1:0]   rd_sel1;
        logic [SelWidth-1:0]   rd_sel2;
        logic                  rd_en1;
        logic                  rd_en2;
        logic                  wr_en;
        logic [SelWidth-1:0]   wr_sel;
        logic                  sel_reg_in_alu_decoder;
        logic                  stat_wr_en;
        logic                  stat_reg_in_alu_decoder;
        logic [StatusBits-1:0] status_out;
        logic                  cnt_wr_en;
        logic                  add_offset;
    } decode_bundle_t;

    function automatic decode_bundle_t nop_bundle();
        decode_bundle_t b;
        b = '0;
        b.stat_reg_in_alu_decoder = SEL_ALU;
        return b;
    endfunction

    function automatic logic is_cond_branch(input logic [OpcodeBits-1:0] op);
        return (op == Op_IFZ) || (op == Op_IFNZ) || (op == Op_IFEQ) ||
               (op == Op_IFST) || (op == Op_IFGT);
    endfunction

endpackage

// File: rtl/decode_logic.sv
// rtl/decode_logic.sv - combinational instruction decode; STATUS_CLEAR_OP_EN enables CLRST
module decode_logic
    import jac_pkg::*;
#(
    parameter int PROG_WIDTH  = 16,
    parameter int OPCODE_BITS = 5,
    parameter int PARAM_BITS  = 8,
    parameter int SEL_WIDTH   = 2,
    parameter int STATUS_BITS = 6,
    parameter int OP1_POS     = 9,
    parameter int OP2_POS     = 4
) (
    input  logic [PROG_WIDTH-1:0]  instruction,
    input  logic [STATUS_BITS-1:0] status,
    output decode_bundle_t         bundle,
    output logic                   illegal,
    output logic                   taken
);

    logic [OPCODE_BITS-1:0] op;
    logic [SEL_WIDTH-1:0]   op1;
    logic [SEL_WIDTH-1:0]   op2;
    logic [PARAM_BITS-1:0]  prm;
    logic                   cond_true;
    logic                   unused_bits;

    assign op  = instruction[PROG_WIDTH-1 -: OPCODE_BITS];
    assign op1 = instruction[OP1_POS -: SEL_WIDTH];
    assign op2 = instruction[OP2_POS -: SEL_WIDTH];
    assign prm = instruction[PARAM_BITS-1:0];
    assign unused_bits = ^{instruction, status};

    always_comb begin
        cond_true = 1'b0;
        case (op)
            Op_IFZ:  cond_true = status[ZeroBit];
            Op_IFNZ: cond_true = !status[ZeroBit];
            Op_IFEQ: cond_true = status[EqualBit];
            Op_IFST: cond_true = status[SmallerThanBit];
            Op_IFGT: cond_true = status[GreaterThanBit];
            default: cond_true = 1'b0;
        endcase
    end

    always_comb begin
        bundle        = nop_bundle();
        bundle.opcode = op;
        illegal       = 1'b0;
        taken         = 1'b0;
        case (op)
            Op_ADD, Op_SUB, Op_AND, Op_OR, Op_XOR, Op_ADDC, Op_SUBU: begin
                bundle.rd_sel1                = op1;
                bundle.rd_sel2                = op2;
                bundle.rd_en1                 = 1'b1;
                bundle.rd_en2                 = 1'b1;
                bundle.wr_en                  = 1'b1;
                bundle.wr_sel                 = op1;
                bundle.sel_reg_in_alu_decoder = SEL_ALU;
                bundle.stat_wr_en             = 1'b1;
            end
            Op_NOT: begin
                bundle.rd_sel2                = op2;
                bundle.rd_en2                 = 1'b1;
                bundle.wr_en                  = 1'b1;
                bundle.wr_sel                 = op1;
                bundle.sel_reg_in_alu_decoder = SEL_ALU;
                bundle.stat_wr_en             = 1'b1;
            end
            Op_SHL, Op_SHR: begin
                bundle.rd_sel1                = op1;
                bundle.rd_en1                 = 1'b1;
                bundle.wr_en                  = 1'b1;
                bundle.wr_sel                 = op1;
                bundle.sel_reg_in_alu_decoder = SEL_ALU;
                bundle.stat_wr_en             = 1'b1;
                bundle.param                  = prm;
            end
            Op_VAL: begin
                bundle.wr_en                  = 1'b1;
                bundle.wr_sel                 = op1;
                bundle.sel_reg_in_alu_decoder = SEL_DECODER;
                bundle.param                  = prm;
            end
            Op_CMP: begin
                bundle.rd_sel1    = op1;
                bundle.rd_sel2    = op2;
                bundle.rd_en1     = 1'b1;
                bundle.rd_en2     = 1'b1;
                bundle.stat_wr_en = 1'b1;
            end
            Op_GOTO: begin
                bundle.cnt_wr_en   = 1'b1;
                bundle.literal_adr = DataWidth'(prm);
                taken              = 1'b1;
            end
            Op_IFZ, Op_IFNZ, Op_IFEQ, Op_IFST, Op_IFGT: begin
                bundle.literal_adr = DataWidth'(prm);
                bundle.cnt_wr_en   = cond_true;
                bundle.add_offset  = cond_true;
                taken              = cond_true;
            end
            Op_NOP: ;
`ifdef STATUS_CLEAR_OP_EN
            Op_CLRST: begin
                bundle.stat_wr_en              = 1'b1;
                bundle.stat_reg_in_alu_decoder = SEL_DECODER;
                bundle.status_out              = prm[StatusBits-1:0];
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// rtl/decode_stage.sv - registered Jac1-8 decode stage with handshake, status interlock and shadow squash
module decode_stage
    import jac_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int SEL_WIDTH    = 2,
    parameter int PROG_WIDTH   = 16,
    parameter int OPCODE_BITS  = 5,
    parameter int PARAM_BITS   = 8,
    parameter int OP1_POS      = 9,
    parameter int OP2_POS      = 4,
    parameter int STATUS_BITS  = 6,
    parameter int STAT_LATENCY = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PROG_WIDTH-1:0]  instruction,
    input  logic [STATUS_BITS-1:0] status,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [OPCODE_BITS-1:0] opcode,
    output logic [PARAM_BITS-1:0]  param,
    output logic [DATA_WIDTH-1:0]  literal_adr,
    output logic [SEL_WIDTH-1:0]   rd_sel1,
    output logic [SEL_WIDTH-1:0]   rd_sel2,
    output logic                   rd_en1,
    output logic                   rd_en2,
    output logic                   wr_en,
    output logic [SEL_WIDTH-1:0]   wr_sel,
    output logic                   sel_reg_in_alu_decoder,
    output logic                   stat_wr_en,
    output logic                   stat_reg_in_alu_decoder,
    output logic [STATUS_BITS-1:0] status_out,
    output logic                   cnt_wr_en,
    output logic                   add_offset,
    output logic                   illegal_op
);

    localparam int PendW = (STAT_LATENCY > 0) ? $clog2(STAT_LATENCY + 1) : 1;

    decode_bundle_t dec;
    decode_bundle_t bundle_q;
    logic           dec_illegal;
    logic           dec_taken;
    logic           squash_q;
    logic [PendW-1:0] pend_cnt;
    logic           hold;
    logic           accept;
    logic           consume;

    decode_logic #(
        .PROG_WIDTH (PROG_WIDTH),
        .OPCODE_BITS(OPCODE_BITS),
        .PARAM_BITS (PARAM_BITS),
        .SEL_WIDTH  (SEL_WIDTH),
        .STATUS_BITS(STATUS_BITS),
        .OP1_POS    (OP1_POS),
        .OP2_POS    (OP2_POS)
    ) u_decode_logic (
        .instruction(instruction),
        .status     (status),
        .bundle     (dec),
        .illegal    (dec_illegal),
        .taken      (dec_taken)
    );

    // A conditional branch must not sample status while a writer is in flight.
    assign hold = in_valid && is_cond_branch(instruction[PROG_WIDTH-1 -: OPCODE_BITS]) &&
                  ((out_valid && bundle_q.stat_wr_en) || (pend_cnt != '0));
    assign in_ready = (!out_valid || out_ready) && !hold;
    assign accept   = in_valid && in_ready;
    assign consume  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            bundle_q   <= nop_bundle();
            illegal_op <= 1'b0;
            squash_q   <= 1'b0;
            pend_cnt   <= '0;
        end else begin
            illegal_op <= accept && dec_illegal && !squash_q;

            if (consume && bundle_q.stat_wr_en)
                pend_cnt <= PendW'(STAT_LATENCY);
            else if (pend_cnt != '0)
                pend_cnt <= pend_cnt - 1'b1;

            if (accept) begin
                out_valid <= 1'b1;
                // The slot fetched behind a taken transfer becomes a bubble.
                if (squash_q) begin
                    bundle_q <= nop_bundle();
                    squash_q <= 1'b0;
                end else begin
                    bundle_q <= dec;
                    squash_q <= dec_taken;
                end
            end else if (consume) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign opcode                  = bundle_q.opcode;
    assign param                   = bundle_q.param;
    assign literal_adr             = bundle_q.literal_adr;
    assign rd_sel1                 = bundle_q.rd_sel1;
    assign rd_sel2                 = bundle_q.rd_sel2;
    assign rd_en1                  = bundle_q.rd_en1;
    assign rd_en2                  = bundle_q.rd_en2;
    assign wr_en                   = bundle_q.wr_en;
    assign wr_sel                  = bundle_q.wr_sel;
    assign sel_reg_in_alu_decoder  = bundle_q.sel_reg_in_alu_decoder;
    assign stat_wr_en              = bundle_q.stat_wr_en;
    assign stat_reg_in_alu_decoder = bundle_q.stat_reg_in_alu_decoder;
    assign status_out              = bundle_q.status_out;
    assign cnt_wr_en               = bundle_q.cnt_wr_en;
    assign add_offset              = bundle_q.add_offset;

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Registered, parametrised instruction-decode pipeline stage for the Jac1-8 core; successor to the combinational decoder.
- Sits between the fetch unit and the register file, ALU and program counter.
- Adds a valid/ready handshake, a status-flag hazard interlock for conditional branches, squashing of the fetch shadow slot after a taken control transfer, and an illegal-opcode pulse.

Parameters:
- DATA_WIDTH, 8, register and literal width
- SEL_WIDTH, 2, register select width
- PROG_WIDTH, 16, instruction width
- OPCODE_BITS, 5, opcode field width; occupies instruction[PROG_WIDTH-1 -: OPCODE_BITS]
- PARAM_BITS, 8, immediate field width; occupies instruction[PARAM_BITS-1:0]
- OP1_POS, 9, MSB of operand-1 select field
- OP2_POS, 4, MSB of operand-2 select field
- STATUS_BITS, 6, status vector width; bit order is C, U, Z, EQ, GT, ST (bits 0 to 5)
- STAT_LATENCY, 1, cycles after a status-writing instruction leaves this stage before `status` is valid

Ports:
- clk, in, 1, clock
- rst_n, in, 1, asynchronous active-low reset
- in_valid, in, 1, fetch offers an instruction
- in_ready, out, 1, stage accepts the instruction
- instruction, in, PROG_WIDTH, instruction word
- status, in, STATUS_BITS, current status register
- out_valid, out, 1, decoded bundle valid
- out_ready, in, 1, downstream consumes the bundle
- opcode, out, OPCODE_BITS, registered opcode
- param, out, PARAM_BITS, registered immediate
- literal_adr, out, DATA_WIDTH, branch target or offset (zero-extended param)
- rd_sel1, rd_sel2, out, SEL_WIDTH each, read selects
- rd_en1, rd_en2, out, 1 each, read enables
- wr_en, out, 1, register write enable
- wr_sel, out, SEL_WIDTH, write select
- sel_reg_in_alu_decoder, out, 1, register write source: 1 = ALU, 0 = decoder
- stat_wr_en, out, 1, status write enable
- stat_reg_in_alu_decoder, out, 1, status write source: 1 = ALU, 0 = decoder
- status_out, out, STATUS_BITS, decoder-sourced status value
- cnt_wr_en, out, 1, program-counter load enable
- add_offset, out, 1, 1 = relative jump, 0 = absolute jump
- illegal_op, out, 1, one-cycle pulse on an accepted reserved opcode

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0 and every bundle output 0, except stat_reg_in_alu_decoder=1.
  - Squash flag and hazard counter cleared; illegal_op=0.
  - Reset mid-handshake drops the in-flight bundle; nothing is replayed.
- Handshake:
  - in_ready = (!out_valid || out_ready) && !hold.
  - Accept on in_valid && in_ready; the bundle is registered and out_valid=1 on the next edge.
  - Latency is 1 cycle. Throughput is 1 per cycle when unstalled.
  - The bundle holds stable while out_valid && !out_ready.
- Decode rules:
  - Every field not named below is 0 and stat_reg_in_alu_decoder=1.
  - ADD, SUB, AND, OR, XOR, ADDC, SUBU: rd_sel1=op1, rd_sel2=op2, rd_en1=rd_en2=1, wr_en=1, wr_sel=op1, sel_reg_in_alu_decoder=1, stat_wr_en=1.
  - NOT: rd_en2=1, rd_sel2=op2, wr_en=1, wr_sel=op1, sel_reg_in_alu_decoder=1, stat_wr_en=1.
  - SHL, SHR: rd_en1=1, rd_sel1=op1, wr_en=1, wr_sel=op1, sel_reg_in_alu_decoder=1, stat_wr_en=1; the shift amount travels in param.
  - VAL: wr_en=1, wr_sel=op1, sel_reg_in_alu_decoder=0, param passed through.
  - CMP: rd_en1=rd_en2=1, rd_sel1=op1, rd_sel2=op2, stat_wr_en=1, wr_en=0.
  - GOTO: cnt_wr_en=1, add_offset=0, literal_adr=param.
  - IFZ, IFNZ, IFEQ, IFST, IFGT: condition tested on `status` at accept time. If taken: cnt_wr_en=1, add_offset=1. If not taken: cnt_wr_en=0, add_offset=0. literal_adr=param either way.
  - NOP: all enables 0.
  - Reserved opcodes (01101-01111, 10110-11111): decoded as NOP; illegal_op pulses in the cycle the bundle first becomes valid.
- Status hazard:
  - hold=1 when in_valid presents a conditional branch AND (out_valid && stat_wr_en of the held bundle, OR pend_cnt != 0).
  - pend_cnt loads STAT_LATENCY when a bundle with stat_wr_en=1 is consumed (out_valid && out_ready). Otherwise it decrements to 0.
  - A simultaneous consume and new stat-writer reload pend_cnt.
  - Non-branch instructions are never held.
- Shadow squash:
  - After accepting a taken conditional branch or a GOTO, the next accepted instruction is emitted as a NOP bundle (out_valid=1, all enables 0, illegal_op suppressed).
  - The squash flag then clears.
  - If the squashed slot is itself a control transfer, it is still squashed and does not re-arm the flag.

Optional Feature:
- Macro: STATUS_CLEAR_OP_EN.
- Defined: opcode 01101 is CLRST. It decodes to stat_wr_en=1, stat_reg_in_alu_decoder=0, status_out=param[STATUS_BITS-1:0] (a status load), loads pend_cnt like any status writer, and does not pulse illegal_op.
- Undefined: 01101 is reserved (NOP plus illegal_op); status_out is constant 0.

Decomposition:
- Package jac_pkg holds:
  - opcode localparams (Op_NOP..Op_IFGT, Op_CLRST)
  - status bit indices (CarryBit..SmallerThanBit)
  - SEL_ALU and SEL_DECODER
  - the decode-bundle struct typedef
- One combinational sub-module, decode_logic, maps instruction and status to the bundle.
- decode_stage adds the pipeline register, handshake, hazard counter and squash flag.

Test Plan:
- ADD r1,r2 (op1=01, op2=10) accepted at cycle 0 -> cycle 1: out_valid=1, rd_sel1=01, rd_sel2=10, wr_sel=01, stat_wr_en=1, add_offset=0.
- VAL r3,0xA5 with out_ready=0 for 3 cycles -> in_ready=0, bundle stable (param=A5, sel_reg_in_alu_decoder=0); next instruction accepted the cycle after out_ready=1.
- CMP then IFEQ back-to-back, STAT_LATENCY=1, status[3]=1 -> IFEQ held 2 cycles, then cnt_wr_en=1, add_offset=1, literal_adr=0x0C.
- IFZ 0x08 with status=0 -> cnt_wr_en=0; IFZ 0x09 with status[2]=1 -> cnt_wr_en=1, and the following ADD is emitted with wr_en=0, stat_wr_en=0.
- Reserved opcode 10110 -> NOP bundle, illegal_op high exactly 1 cycle; with STATUS_CLEAR_OP_EN, 01101 param=0x15 -> status_out=010101, stat_reg_in_alu_decoder=0.
- rst_n low while out_valid=1 and pend_cnt=1 -> out_valid=0 immediately, stat_reg_in_alu_decoder=1; the first IFEQ after release is not held.
